mem_sdp_pipe: RTL and testbench

//  Simple-dual-port behavioural memory. One write port and one read port operate in the same cycle.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_sdp_pipe_if.sv | 30 +++
 rtl/mem_rd_pipe.sv | 51 +++++
 rtl/mem_sdp_pipe.sv | 126 ++++++++++++
 tb/tb_mem_sdp_pipe.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and limits for the simple-dual-port memory family.
//   mem_collision_e : same-address read/write ordering policy
//   mem_state_e     : clear-sequencer state
//   MEM_MAX_RD_LATENCY : deepest supported read pipeline
package mem_pkg;

   typedef enum logic {
      READ_FIRST,
      WRITE_FIRST
   } mem_collision_e;

   typedef enum logic {
      MEM_INIT,
      MEM_READY
   } mem_state_e;

   localparam int unsigned MEM_MAX_RD_LATENCY = 4;

endpackage

// File: rtl/mem_sdp_pipe_if.sv
// Request/response bundle for mem_sdp_pipe.
//   i_wr_cenb/i_wr_addr/i_wr_data/i_wr_mask : write port (request active low, byte enables)
//   i_rd_cenb/i_rd_addr                     : read port (request active low)
//   o_rd_data/o_rd_valid                    : pipelined read response
//   o_ready                                 : array cleared, requests accepted
// master drives requests, slave (the memory) drives responses.
interface mem_sdp_pipe_if #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                    i_wr_cenb;
   logic [ADDR_WIDTH-1:0]   i_wr_addr;
   logic [DATA_WIDTH-1:0]   i_wr_data;
   logic [DATA_WIDTH/8-1:0] i_wr_mask;
   logic                    i_rd_cenb;
   logic [ADDR_WIDTH-1:0]   i_rd_addr;
   logic [DATA_WIDTH-1:0]   o_rd_data;
   logic                    o_rd_valid;
   logic                    o_ready;

   modport master (
      output i_wr_cenb, i_wr_addr, i_wr_data, i_wr_mask, i_rd_cenb, i_rd_addr,
      input  o_rd_data, o_rd_valid, o_ready
   );

   modport slave (
      input  i_wr_cenb, i_wr_addr, i_wr_data, i_wr_mask, i_rd_cenb, i_rd_addr,
      output o_rd_data, o_rd_valid, o_ready
   );
endinterface

// File: rtl/mem_rd_pipe.sv
// Read-response pipeline: RD_LATENCY stages of {valid,data} followed by an
// output register. The output data register only loads on a valid beat so the
// last returned word is held between strobes.
//   clk, rst_n : clock, asynchronous active-low reset (flushes all stages)
//   in_valid   : read accepted this edge
//   in_data    : array word sampled at the request edge
//   out_valid  : one-cycle strobe, RD_LATENCY edges after the request edge
//   out_data   : returned word, held when out_valid=0
module mem_rd_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [RD_LATENCY-1:0] vld_q;
   logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= in_valid;
         dat_q[0] <= in_data;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
         out_valid_q <= vld_q[RD_LATENCY-1];
         if (vld_q[RD_LATENCY-1]) begin
            out_data_q <= dat_q[RD_LATENCY-1];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: rtl/mem_sdp_pipe.sv
// Simple-dual-port behavioural memory with byte-masked writes, a pipelined
// read port and a post-reset clear sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_sdp_pipe_if slave (write port, read port, read response, o_ready)
// After reset the INIT state writes zero to one entry per cycle; requests are
// dropped until every entry is cleared, then o_ready rises and stays high.
// Out-of-range writes are ignored; out-of-range reads return zero with valid.
module mem_sdp_pipe
   import mem_pkg::*;
#(
   parameter int unsigned    NUM_ENTRIES = 64,
   parameter int unsigned    DATA_WIDTH  = 32,
   parameter int unsigned    RD_LATENCY  = 1,
   parameter mem_collision_e COLLISION   = READ_FIRST,
   parameter int unsigned    ADDR_WIDTH  = $clog2(NUM_ENTRIES)
) (
   input logic            clk,
   input logic            rst_n,
   mem_sdp_pipe_if.slave  bus
);

   localparam int unsigned           NUM_BYTES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ENTRIES - 1);
   // One extra bit so NUM_ENTRIES itself is representable for range checks.
   localparam logic [ADDR_WIDTH:0]   NUM_ENT_W = (ADDR_WIDTH + 1)'(NUM_ENTRIES);

   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("mem_sdp_pipe: DATA_WIDTH must be a multiple of 8");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > MEM_MAX_RD_LATENCY) begin : g_bad_latency
      $error("mem_sdp_pipe: RD_LATENCY out of range");
   end

   mem_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [NUM_ENTRIES];

   logic                  ready;
   logic                  wr_en;
   logic                  rd_en;
   logic                  rd_in_range;
   logic                  collide;
   logic [DATA_WIDTH-1:0] rd_old;
   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] rd_word;

   // Clear sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MEM_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         MEM_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = MEM_READY;
               cnt_d   = '0;
            end
         end
         MEM_READY: begin
            state_d = MEM_READY;
         end
         default: begin
            state_d = MEM_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   assign ready       = (state_q == MEM_READY);
   assign wr_en       = ready && !bus.i_wr_cenb && ({1'b0, bus.i_wr_addr} < NUM_ENT_W);
   assign rd_en       = ready && !bus.i_rd_cenb;
   assign rd_in_range = {1'b0, bus.i_rd_addr} < NUM_ENT_W;

   // Array: no reset, the clear sequencer owns initialisation.
   always_ff @(posedge clk) begin
      if (state_q == MEM_INIT) begin
         mem_q[cnt_q] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (bus.i_wr_mask[b]) begin
               mem_q[bus.i_wr_addr][8*b +: 8] <= bus.i_wr_data[8*b +: 8];
            end
         end
      end
   end

   assign rd_old  = rd_in_range ? mem_q[bus.i_rd_addr] : '0;
   // wr_en already implies the write address is in range, so a match does too.
   assign collide = wr_en && (bus.i_rd_addr == bus.i_wr_addr);

   always_comb begin
      merged = rd_old;
      for (int b = 0; b < NUM_BYTES; b++) begin
         if (bus.i_wr_mask[b]) begin
            merged[8*b +: 8] = bus.i_wr_data[8*b +: 8];
         end
      end
   end

   assign rd_word = (COLLISION == WRITE_FIRST && collide) ? merged : rd_old;

   mem_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_en),
      .in_data   (rd_word),
      .out_valid (bus.o_rd_valid),
      .out_data  (bus.o_rd_data)
   );

   assign bus.o_ready = ready;

endmodule

// File: tb/tb_mem_sdp_pipe.sv
// Two instances share one stimulus stream:
//   dut_a : 64 entries, RD_LATENCY=3, READ_FIRST
//   dut_b : 48 entries, RD_LATENCY=1, WRITE_FIRST (addresses 48..63 are out of range)
// Expected responses (data and arrival cycle) are queued when a read is issued;
// a forked monitor pops and compares on every o_rd_valid strobe.
module tb_mem_sdp_pipe;
   import mem_pkg::*;

   localparam int unsigned LAT_A = 3;
   localparam int unsigned LAT_B = 1;

   typedef struct {
      logic [31:0] data;
      int unsigned due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   exp_t        q_a[$];
   exp_t        q_b[$];

   mem_sdp_pipe_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus_a ();
   mem_sdp_pipe_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus_b ();

   mem_sdp_pipe #(
      .NUM_ENTRIES (64),
      .DATA_WIDTH  (32),
      .RD_LATENCY  (LAT_A),
      .COLLISION   (READ_FIRST)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   mem_sdp_pipe #(
      .NUM_ENTRIES (48),
      .DATA_WIDTH  (32),
      .RD_LATENCY  (LAT_B),
      .COLLISION   (WRITE_FIRST)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic wr, input logic [5:0] wa, input logic [31:0] wd,
                        input logic [3:0] wm, input logic rd, input logic [5:0] ra);
      bus_a.i_wr_cenb = ~wr;  bus_b.i_wr_cenb = ~wr;
      bus_a.i_wr_addr = wa;   bus_b.i_wr_addr = wa;
      bus_a.i_wr_data = wd;   bus_b.i_wr_data = wd;
      bus_a.i_wr_mask = wm;   bus_b.i_wr_mask = wm;
      bus_a.i_rd_cenb = ~rd;  bus_b.i_rd_cenb = ~rd;
      bus_a.i_rd_addr = ra;   bus_b.i_rd_addr = ra;
   endtask

   task automatic idle();
      drive(1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 6'd0);
   endtask

   // One request cycle; called at a negedge, returns at the next negedge.
   task automatic issue(input logic wr, input logic [5:0] wa, input logic [31:0] wd,
                        input logic [3:0] wm, input logic rd, input logic [5:0] ra,
                        input logic [31:0] exp_a, input logic [31:0] exp_b);
      exp_t e;
      drive(wr, wa, wd, wm, rd, ra);
      if (rd) begin
         e.data = exp_a; e.due = cyc + 1 + LAT_A; q_a.push_back(e);
         e.data = exp_b; e.due = cyc + 1 + LAT_B; q_b.push_back(e);
      end
      @(negedge clk);
      idle();
   endtask

   task automatic rd(input logic [5:0] ra, input logic [31:0] exp_a, input logic [31:0] exp_b);
      issue(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, ra, exp_a, exp_b);
   endtask

   task automatic wr(input logic [5:0] wa, input logic [31:0] wd, input logic [3:0] wm);
      issue(1'b1, wa, wd, wm, 1'b0, 6'd0, 32'h0, 32'h0);
   endtask

   // Called at the negedge of reset release; counts edges until each o_ready.
   // Requests driven mid-INIT must be dropped (entry 3 is already cleared then).
   task automatic wait_init();
      int n = 0;
      int na = 0;
      int nb = 0;
      while ((!bus_a.o_ready || !bus_b.o_ready) && n < 200) begin
         if (n == 20) drive(1'b1, 6'd3, 32'hFFFF_FFFF, 4'hF, 1'b1, 6'd3);
         if (n == 40) idle();
         @(negedge clk);
         n++;
         if (bus_a.o_ready && na == 0) na = n;
         if (bus_b.o_ready && nb == 0) nb = n;
      end
      idle();
      check("init_cycles_a", na, 64);
      check("init_cycles_b", nb, 48);
   endtask

   task automatic drain();
      int n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", q_a.size() + q_b.size(), 0);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus_a.o_rd_valid) begin
            n_vec++;
            if (q_a.size() == 0) begin
               n_err++;
               $display("FAIL rsp_a: unexpected strobe data %h at cycle %0d", bus_a.o_rd_data, cyc);
            end else begin
               e = q_a.pop_front();
               if (bus_a.o_rd_data !== e.data || cyc != e.due) begin
                  n_err++;
                  $display("FAIL rsp_a: got %h at cycle %0d, expected %h at cycle %0d",
                           bus_a.o_rd_data, cyc, e.data, e.due);
               end
            end
         end
         if (bus_b.o_rd_valid) begin
            n_vec++;
            if (q_b.size() == 0) begin
               n_err++;
               $display("FAIL rsp_b: unexpected strobe data %h at cycle %0d", bus_b.o_rd_data, cyc);
            end else begin
               e = q_b.pop_front();
               if (bus_b.o_rd_data !== e.data || cyc != e.due) begin
                  n_err++;
                  $display("FAIL rsp_b: got %h at cycle %0d, expected %h at cycle %0d",
                           bus_b.o_rd_data, cyc, e.data, e.due);
               end
            end
         end
      end
   endtask

   initial begin
      idle();
      fork
         monitor();
      join_none

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_ready_a", {31'b0, bus_a.o_ready}, 32'h0);
      check("rst_ready_b", {31'b0, bus_b.o_ready}, 32'h0);
      check("rst_valid_a", {31'b0, bus_a.o_rd_valid}, 32'h0);
      check("rst_valid_b", {31'b0, bus_b.o_rd_valid}, 32'h0);
      check("rst_data_a", bus_a.o_rd_data, 32'h0);
      check("rst_data_b", bus_b.o_rd_data, 32'h0);

      rst_n = 1'b1;
      wait_init();

      // Whole array back-to-back: cleared, in order, no gaps (arrival cycles checked).
      for (int i = 0; i < 64; i++) rd(6'(i), 32'h0, 32'h0);

      // Full write then read.
      wr(6'd5, 32'hDEAD_BEEF, 4'hF);
      rd(6'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

      // Empty mask is a no-op.
      wr(6'd5, 32'h1234_5678, 4'h0);
      rd(6'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

      // Byte-masked merge.
      wr(6'd7, 32'h1122_3344, 4'hF);
      wr(6'd7, 32'hAABB_CCDD, 4'b0101);
      rd(6'd7, 32'h11BB_33DD, 32'h11BB_33DD);

      // Same-address collision: A is READ_FIRST, B is WRITE_FIRST.
      issue(1'b1, 6'd9, 32'hCAFE_F00D, 4'hF, 1'b1, 6'd9, 32'h0, 32'hCAFE_F00D);
      rd(6'd9, 32'hCAFE_F00D, 32'hCAFE_F00D);
      drain();
      repeat (2) @(negedge clk);
      check("hold_data_a", bus_a.o_rd_data, 32'hCAFE_F00D);
      check("hold_data_b", bus_b.o_rd_data, 32'hCAFE_F00D);

      // Address 50 exists only in A; B ignores the write and reads zero.
      wr(6'd50, 32'h5A5A_5A5A, 4'hF);
      rd(6'd50, 32'h5A5A_5A5A, 32'h0);
      rd(6'd2, 32'h0, 32'h0);
      // Dropped INIT-time write to entry 3 must not have landed.
      rd(6'd3, 32'h0, 32'h0);
      drain();

      // Reset with reads in flight.
      rd(6'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      rd(6'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      @(posedge clk);
      #2;
      check("pre_rst_valid_b", {31'b0, bus_b.o_rd_valid}, 32'h1);
      rst_n = 1'b0;
      q_a.delete();
      q_b.delete();
      #1;
      check("mid_rst_valid_a", {31'b0, bus_a.o_rd_valid}, 32'h0);
      check("mid_rst_valid_b", {31'b0, bus_b.o_rd_valid}, 32'h0);
      check("mid_rst_ready_a", {31'b0, bus_a.o_ready}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_init();
      rd(6'd5, 32'h0, 32'h0);
      rd(6'd7, 32'h0, 32'h0);
      drain();
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
